// File: rtl/seq_divider_8by4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit per cycle, MSB first; divide-by-zero short-circuits.
module seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] part_q, part_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dz_q, dz_d;
  logic       done_q, done_d;

  logic [4:0] shifted;
  logic [3:0] diff;
  logic [3:0] part_nx;
  logic       qbit;

  // Stored remainder is always < divisor, so its 4 bits plus the
  // shifted-in dividend bit form the 5-bit working remainder.
  assign shifted = {part_q, dvd_q[7]};
  assign qbit    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[3:0] - dvs_q;
  assign part_nx = qbit ? diff : shifted[3:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          part_d  = 4'h0;
          cnt_d   = 4'h0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dvs_q == 4'h0) begin
          quot_d  = 8'hFF;
          rem_d   = dvd_q[3:0];
          dz_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Quotient bits fill the dividend register from the LSB.
          part_d = part_nx;
          dvd_d  = {dvd_q[6:0], qbit};
          cnt_d  = cnt_q + 4'h1;
          if (cnt_q == 4'h7) begin
            quot_d  = {dvd_q[6:0], qbit};
            rem_d   = part_nx;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 4'h0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      dvd_q   <= 8'h00;
      dvs_q   <= 4'h0;
      part_q  <= 4'h0;
      quot_q  <= 8'h00;
      rem_q   <= 4'h0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4.
// Table vectors, corner sequences and an exhaustive sweep via a scoreboard.
module tb_seq_divider_8by4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  seq_divider_8by4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];
  int   n_vec;
  int   n_bad;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done cyc=%0d q=%0d r=%0d dz=%b",
                 cyc, quotient, remainder, div_by_zero);
      end else begin
        mon_e = sb.pop_front();
        if (quotient !== mon_e.q || remainder !== mon_e.r ||
            div_by_zero !== mon_e.dz || cyc != mon_e.due ||
            busy !== 1'b0) begin
          n_bad++;
          $display("FAIL div %0d/%0d: got q=%0d r=%0d dz=%b busy=%b cyc=%0d, want q=%0d r=%0d dz=%b busy=0 cyc=%0d",
                   mon_e.a, mon_e.b, quotient, remainder, div_by_zero,
                   busy, cyc, mon_e.q, mon_e.r, mon_e.dz, mon_e.due);
        end
      end
    end
  end

  // Caller must be at a falling edge; start is sampled on the next rise.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r,
                       input logic dz);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.due = cyc + ((b == 4'h0) ? 2 : 9);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Returns at the falling edge where done is high.
  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: done not seen, got done=%b want done=1", done);
      sb.delete();
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    if (b == 4'h0) begin
      q  = 8'hFF;
      r  = a[3:0];
      dz = 1'b1;
    end else begin
      q  = a / {4'h0, b};
      r  = 4'(a % {4'h0, b});
      dz = 1'b0;
    end
    issue(a, b, q, r, dz);
    wait_done();
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;

    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
    tbl[3] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0};
    tbl[4] = '{8'd13,  4'd0,  8'hFF,  4'd13, 1'b1};
    tbl[5] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    tbl[6] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0};
    tbl[7] = '{8'd0,   4'd0,  8'hFF,  4'd0,  1'b1};
    tbl[8] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
    tbl[9] = '{8'd77,  4'd5,  8'd15,  4'd2,  1'b0};

    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end

    // First start right after reset release, then back-to-back table.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
      wait_done();
    end

    // 200/7 with busy/hold checks and a stray start at E3.
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd15 ||
          remainder !== 4'd2 || div_by_zero !== 1'b0) begin
        n_bad++;
        $display("FAIL run_hold k=%0d: got busy=%b done=%b q=%0d r=%0d dz=%b, want busy=1 done=0 q=15 r=2 dz=0",
                 k, busy, done, quotient, remainder, div_by_zero);
      end
      if (k == 3) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd3;
      end
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
    wait_done();
    run(8'd100, 4'd9);

    // Asynchronous reset in the middle of a run.
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || quotient !== 8'h00) begin
      n_bad++;
      $display("FAIL post_abort: got busy=%b q=%0d, want busy=0 q=0",
               busy, quotient);
    end
    run(8'd200, 4'd7);
    run(8'd13, 4'd0);

    // Every operand pair, back to back.
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run(8'(a), 4'(b));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_8by4.md
SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed and are the inverse of the 4x4 multiplier (8-bit product in, 4-bit factor in).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a division; sampled on rising clk.
REQ-006 dividend  input  8  unsigned dividend; sampled only on the accepted start edge.
REQ-007 divisor  input  4  unsigned divisor; sampled only on the accepted start edge.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 quotient  output  8  unsigned quotient.
REQ-011 remainder  output  4  unsigned remainder.
REQ-012 div_by_zero  output  1  high with done when the latched divisor was 0.

Function
REQ-013 FSM states SHALL be IDLE and RUN, plus a 4-bit iteration counter.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch dividend and divisor, clear the 5-bit partial remainder, set busy=1, and enter RUN.
REQ-015 If the latched divisor is 0, the block SHALL skip RUN: at E1 it SHALL set quotient=8'hFF, remainder=dividend[3:0], div_by_zero=1, done=1, busy=0, state IDLE.
REQ-016 RUN SHALL perform restoring division MSB first, one quotient bit per cycle: shift {partial,dividend} left 1; if partial >= {1'b0,divisor}, subtract and set the quotient bit to 1, else set it to 0.
REQ-017 The partial remainder SHALL be 5 bits wide so the shifted value never overflows; the subtraction result SHALL always fit in 4 bits.
REQ-018 Iterations SHALL occur at E1..E8; at E8 quotient and remainder SHALL be registered, done=1, div_by_zero=0, busy=0, and the state SHALL return to IDLE.
REQ-019 Latency from the start edge to done high SHALL be 8 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-020 done SHALL be high for exactly one cycle per accepted start.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from done until the next done; they SHALL not change during RUN.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 start in the cycle done is high SHALL be accepted (state is IDLE), giving back-to-back operation with a new operation every 9 cycles.
REQ-024 dividend and divisor SHALL be don't-care in all cycles except the accepted start edge.
REQ-025 For every nonzero divisor the results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, quotient=8'h00, remainder=4'h0, div_by_zero=0, independent of clk.
REQ-027 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-029 200/7: start at E0 -> done at E8 with quotient=8'd28, remainder=4'd4, div_by_zero=0; busy high E0..E8.
REQ-030 255/15 -> quotient=8'd17, remainder=4'd0; 5/9 -> quotient=8'd0, remainder=4'd5; 0/1 -> quotient=8'd0, remainder=4'd0.
REQ-031 13/0 -> done one cycle after start with quotient=8'hFF, remainder=4'd13, div_by_zero=1.
REQ-032 start pulsed at E3 during 200/7 -> ignored; result unchanged. New start in the done cycle -> accepted, next done 8 cycles later.
REQ-033 rst_n low at E4 of a running division -> outputs cleared asynchronously; no done pulse; the next start runs normally.
REQ-034 Exhaustive check of all 256x16 operand pairs, back to back -> REQ-025 holds for every nonzero divisor and REQ-015 for divisor 0.
